// File: rtl/flash_sched.sv
// Two-port scheduler in front of the SPI flash slave: round-robin grant,
// busy (rty) backoff with bounded re-issues, and a per-attempt watchdog.
module flash_sched #(
  parameter int unsigned RETRY_GAP = 100000,
  parameter int unsigned MAX_RETRY = 1023,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_erase,
  input  logic [23:0] a_adr,
  input  logic [31:0] a_dat,
  output logic [31:0] a_rdat,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_erase,
  input  logic [23:0] b_adr,
  input  logic [31:0] b_dat,
  output logic [31:0] b_rdat,
  output logic        b_ack,
  output logic        b_err,
  output logic [23:0] f_adr,
  output logic [31:0] f_dat,
  output logic        f_we,
  output logic        f_tga,
  output logic        f_stb,
  input  logic [31:0] f_rdat,
  input  logic        f_ack,
  input  logic        f_rty,
  output logic        busy_o,
  output logic [9:0]  retry_cnt_o
);

  localparam int unsigned GAP_W = $clog2(RETRY_GAP + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned RC_W  = 10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BACKOFF, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_prio_b, w_prio_b_nxt;
  logic              r_sel_b, w_sel_b_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic [RC_W-1:0]   w_retry_nxt;
  logic [23:0]       w_adr_nxt;
  logic [31:0]       w_dat_nxt, w_a_rdat_nxt, w_b_rdat_nxt;
  logic              w_we_nxt, w_tga_nxt, w_stb_nxt;
  logic              w_a_ack_nxt, w_a_err_nxt, w_b_ack_nxt, w_b_err_nxt;
  logic              w_grant_b, w_err;

  // B wins only when A is idle or B is the port not served last
  assign w_grant_b = b_req && (!a_req || r_prio_b);

  always_comb begin
    w_state_nxt   = r_state;
    w_prio_b_nxt  = r_prio_b;
    w_sel_b_nxt   = r_sel_b;
    w_gap_cnt_nxt = r_gap_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_retry_nxt   = retry_cnt_o;
    w_adr_nxt     = f_adr;
    w_dat_nxt     = f_dat;
    w_we_nxt      = f_we;
    w_tga_nxt     = f_tga;
    w_stb_nxt     = f_stb;
    w_a_rdat_nxt  = a_rdat;
    w_b_rdat_nxt  = b_rdat;
    w_a_ack_nxt   = 1'b0;
    w_b_ack_nxt   = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_state_nxt  = S_ISSUE;
          w_sel_b_nxt  = w_grant_b;
          w_prio_b_nxt = !w_grant_b;
          w_adr_nxt    = w_grant_b ? b_adr : a_adr;
          w_dat_nxt    = w_grant_b ? b_dat : a_dat;
          w_we_nxt     = w_grant_b ? b_we : a_we;
          w_tga_nxt    = w_grant_b ? (b_we && b_erase) : (a_we && a_erase);
          w_stb_nxt    = 1'b1;
          w_retry_nxt  = '0;
          w_to_cnt_nxt = '0;
        end
      end
      S_ISSUE: begin
        if (f_ack) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_GAP;
          if (r_sel_b) begin
            w_b_ack_nxt  = 1'b1;
            w_b_rdat_nxt = f_rdat;
          end else begin
            w_a_ack_nxt  = 1'b1;
            w_a_rdat_nxt = f_rdat;
          end
        end else if (f_rty) begin
          w_stb_nxt = 1'b0;
          if (retry_cnt_o < RC_W'(MAX_RETRY)) begin
            w_retry_nxt   = retry_cnt_o + RC_W'(1);
            w_gap_cnt_nxt = '0;
            w_state_nxt   = S_BACKOFF;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_GAP;
          end
        end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
          w_err       = 1'b1;
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_GAP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_BACKOFF: begin
        if (r_gap_cnt == GAP_W'(RETRY_GAP - 1)) begin
          w_stb_nxt    = 1'b1;
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_ISSUE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      S_GAP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_a_err_nxt = w_err && !r_sel_b;
    w_b_err_nxt = w_err && r_sel_b;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prio_b    <= 1'b0;
      r_sel_b     <= 1'b0;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
      retry_cnt_o <= '0;
      busy_o      <= 1'b0;
      f_adr       <= '0;
      f_dat       <= '0;
      f_we        <= 1'b0;
      f_tga       <= 1'b0;
      f_stb       <= 1'b0;
      a_rdat      <= '0;
      b_rdat      <= '0;
      a_ack       <= 1'b0;
      a_err       <= 1'b0;
      b_ack       <= 1'b0;
      b_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prio_b    <= w_prio_b_nxt;
      r_sel_b     <= w_sel_b_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      retry_cnt_o <= w_retry_nxt;
      busy_o      <= (w_state_nxt != S_IDLE);
      f_adr       <= w_adr_nxt;
      f_dat       <= w_dat_nxt;
      f_we        <= w_we_nxt;
      f_tga       <= w_tga_nxt;
      f_stb       <= w_stb_nxt;
      a_rdat      <= w_a_rdat_nxt;
      b_rdat      <= w_b_rdat_nxt;
      a_ack       <= w_a_ack_nxt;
      a_err       <= w_a_err_nxt;
      b_ack       <= w_b_ack_nxt;
      b_err       <= w_b_err_nxt;
    end
  end

endmodule

// File: tb/tb_flash_sched.sv
// Bench for flash_sched: scripted flash responder, transaction table,
// randomized transactions against an outcome model, and corner sequences.
module tb_flash_sched;

  localparam int unsigned RETRY_GAP = 10;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned TIMEOUT   = 64;
  localparam int BUDGET = (MAX_RETRY + 2) * (TIMEOUT + RETRY_GAP + 4) + 20;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, a_erase = 1'b0;
  logic [23:0] a_adr = '0;
  logic [31:0] a_dat = '0;
  logic [31:0] a_rdat;
  logic        a_ack, a_err;
  logic        b_req = 1'b0, b_we = 1'b0, b_erase = 1'b0;
  logic [23:0] b_adr = '0;
  logic [31:0] b_dat = '0;
  logic [31:0] b_rdat;
  logic        b_ack, b_err;
  logic [23:0] f_adr;
  logic [31:0] f_dat;
  logic        f_we, f_tga, f_stb;
  logic [31:0] f_rdat = '0;
  logic        f_ack = 1'b0, f_rty = 1'b0;
  logic        busy_o;
  logic [9:0]  retry_cnt_o;

  flash_sched #(.RETRY_GAP(RETRY_GAP), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_req(a_req), .a_we(a_we), .a_erase(a_erase), .a_adr(a_adr), .a_dat(a_dat),
    .a_rdat(a_rdat), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_erase(b_erase), .b_adr(b_adr), .b_dat(b_dat),
    .b_rdat(b_rdat), .b_ack(b_ack), .b_err(b_err),
    .f_adr(f_adr), .f_dat(f_dat), .f_we(f_we), .f_tga(f_tga), .f_stb(f_stb),
    .f_rdat(f_rdat), .f_ack(f_ack), .f_rty(f_rty),
    .busy_o(busy_o), .retry_cnt_o(retry_cnt_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // fin: 0 = ack, 1 = never answer, 2 = rty forever, 3 = ack and rty together
  typedef struct {
    int port; logic we; logic erase; logic [23:0] adr; logic [31:0] dat;
    int n_rty; int fin; int dly; logic [31:0] rdat;
    bit exp_ok; int exp_retry; int exp_issues;
  } vec_t;
  typedef struct { int port; bit err; logic [31:0] rdat; bit stb; bit busy; int cyc; } ev_t;
  typedef struct { logic [23:0] adr; logic [31:0] dat; logic we; logic tga; } iss_t;

  ev_t  evq[$];
  iss_t issq[$];
  int   gapq[$];
  int   cyc = 0, stb_cnt = 0, low_cnt = 0, first_rise = 0, last_rise = 0;
  bit   prev_stb = 1'b0, in_txn = 1'b0;
  int   fl_rty_n = 0, fl_fin = 0, fl_dly = 0;
  logic [31:0] fl_rdat = '0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: act as the flash slave and record everything the DUT shows
  task automatic step();
    ev_t  e;
    iss_t s;
    @(posedge clk_i);
    #1;
    cyc++;
    f_ack  = 1'b0;
    f_rty  = 1'b0;
    f_rdat = $urandom;
    e.stb = f_stb; e.busy = busy_o; e.cyc = cyc;
    if (a_ack || a_err) begin
      e.port = 0; e.err = a_err; e.rdat = a_rdat; evq.push_back(e);
    end
    if (b_ack || b_err) begin
      e.port = 1; e.err = b_err; e.rdat = b_rdat; evq.push_back(e);
    end
    if (f_stb) begin
      if (!prev_stb) begin
        s.adr = f_adr; s.dat = f_dat; s.we = f_we; s.tga = f_tga;
        issq.push_back(s);
        if (in_txn) gapq.push_back(low_cnt);
        else first_rise = cyc;
        in_txn = 1'b1; stb_cnt = 0; last_rise = cyc;
      end else begin
        stb_cnt++;
      end
      if (stb_cnt == fl_dly) begin
        if (fl_rty_n > 0) begin
          f_rty = 1'b1; fl_rty_n--;
        end else if (fl_fin == 0 || fl_fin == 3) begin
          f_ack = 1'b1; f_rdat = fl_rdat; f_rty = (fl_fin == 3);
        end else if (fl_fin == 2) begin
          f_rty = 1'b1;
        end
      end
    end else begin
      low_cnt = prev_stb ? 1 : low_cnt + 1;
    end
    prev_stb = f_stb;
  endtask

  // Outcome from the retry/timeout rules: each busy answer spends one re-issue
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int busy_answers = (v.fin == 2) ? int'(MAX_RETRY) + 1 : v.n_rty;
    if (busy_answers > int'(MAX_RETRY)) begin
      r.exp_ok = 1'b0; r.exp_retry = MAX_RETRY; r.exp_issues = MAX_RETRY + 1;
    end else begin
      r.exp_ok = (v.fin == 0 || v.fin == 3);
      r.exp_retry = busy_answers; r.exp_issues = busy_answers + 1;
    end
    return r;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " ctl"}, {f_stb, busy_o, f_we, f_tga, a_ack, a_err, b_ack, b_err, retry_cnt_o, f_adr}, '0);
    chk({tag, " dat"}, {f_dat, a_rdat}, '0);
    chk({tag, " brdat"}, b_rdat, '0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   n = 0, req_cyc, exp_lat;
    ev_t  e;
    evq.delete(); issq.delete(); gapq.delete(); in_txn = 1'b0;
    fl_rty_n = v.n_rty; fl_fin = v.fin; fl_dly = v.dly; fl_rdat = v.rdat;
    if (v.port == 0) begin
      a_we = v.we; a_erase = v.erase; a_adr = v.adr; a_dat = v.dat; a_req = 1'b1;
    end else begin
      b_we = v.we; b_erase = v.erase; b_adr = v.adr; b_dat = v.dat; b_req = 1'b1;
    end
    req_cyc = cyc;
    while (evq.size() == 0 && n < BUDGET) begin
      step(); n++;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk({tag, " completion"}, evq.size() > 0, 1'b1);
    if (evq.size() == 0) return;
    step(); step();
    e = evq[0];
    exp_lat = (v.fin == 1 && v.exp_issues == v.n_rty + 1) ? int'(TIMEOUT) : v.dly + 1;
    chk({tag, " req->stb"}, first_rise - req_cyc, 1);
    chk({tag, " port"}, e.port, v.port);
    chk({tag, " err"}, e.err, !v.exp_ok);
    chk({tag, " stb/busy at done"}, {e.stb, e.busy}, 2'b01);
    chk({tag, " done latency"}, e.cyc - last_rise, exp_lat);
    if (v.exp_ok) chk({tag, " rdat"}, e.rdat, v.rdat);
    chk({tag, " events"}, evq.size(), 1);
    chk({tag, " issues"}, issq.size(), v.exp_issues);
    chk({tag, " retry_cnt"}, retry_cnt_o, v.exp_retry);
    chk({tag, " busy idle"}, busy_o, 1'b0);
    foreach (issq[i])
      chk({tag, " fields"}, {issq[i].adr, issq[i].dat, issq[i].we, issq[i].tga},
          {v.adr, v.dat, v.we, v.we & v.erase});
    foreach (gapq[i]) chk({tag, " backoff gap"}, gapq[i], RETRY_GAP);
  endtask

  vec_t tbl[9];

  initial begin
    ev_t e;
    int  order[$];
    int  n;
    bit  re_a;
    vec_t v;

    tbl[0] = '{0, 1'b0, 1'b0, 24'h123456, 32'h0,        0, 0, 40, 32'hDEADBEEF, 1'b1, 0, 1};
    tbl[1] = '{1, 1'b1, 1'b1, 24'h001000, 32'h0,        0, 0,  1, 32'h0,        1'b1, 0, 1};
    tbl[2] = '{0, 1'b0, 1'b0, 24'h002004, 32'h0,        3, 0,  2, 32'h12345678, 1'b1, 3, 4};
    tbl[3] = '{0, 1'b0, 1'b0, 24'h00ABCD, 32'h0,        4, 0,  2, 32'h0,        1'b0, 3, 4};
    tbl[4] = '{1, 1'b1, 1'b0, 24'h0F0F0F, 32'hCAFEF00D, 0, 2,  5, 32'h0,        1'b0, 3, 4};
    tbl[5] = '{0, 1'b0, 1'b1, 24'hFFFFFF, 32'h0,        0, 0,  0, 32'hA5A55A5A, 1'b1, 0, 1};
    tbl[6] = '{1, 1'b0, 1'b0, 24'h000010, 32'h0,        0, 0, 63, 32'h0BADF00D, 1'b1, 0, 1};
    tbl[7] = '{1, 1'b0, 1'b0, 24'h000020, 32'h0,        0, 1,  0, 32'h0,        1'b0, 0, 1};
    tbl[8] = '{0, 1'b1, 1'b0, 24'h000030, 32'h11112222, 2, 1,  0, 32'h0,        1'b0, 2, 3};

    repeat (3) step();
    chk_reset("reset");
    rst_i = 1'b0;
    step();

    // Simultaneous requests after reset: A, then B, then A's immediate re-request
    fl_rty_n = 0; fl_fin = 0; fl_dly = 3; evq.delete(); in_txn = 1'b0;
    a_we = 1'b0; a_adr = 24'h00A000; b_we = 1'b0; b_adr = 24'h00B000;
    a_req = 1'b1; b_req = 1'b1;
    re_a = 1'b0; n = 0;
    while (order.size() < 3 && n < 400) begin
      step(); n++;
      if (re_a) begin a_req = 1'b1; re_a = 1'b0; end
      while (evq.size() > 0) begin
        e = evq.pop_front();
        order.push_back(e.port);
        if (e.port == 0) begin
          a_req = 1'b0;
          if (order.size() == 1) re_a = 1'b1;
        end else begin
          b_req = 1'b0;
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("arb count", order.size(), 3);
    if (order.size() == 3) chk("arb order", {order[0][1:0], order[1][1:0], order[2][1:0]}, 6'b00_01_00);
    step(); step();

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while backing off: nothing completes, later request served normally
    evq.delete(); issq.delete(); in_txn = 1'b0;
    fl_rty_n = 5; fl_fin = 0; fl_dly = 1;
    a_we = 1'b0; a_adr = 24'h0C0C0C; a_req = 1'b1;
    n = 0;
    while (!(in_txn && !f_stb && busy_o) && n < 200) begin step(); n++; end
    chk("reach backoff", retry_cnt_o, 1);
    a_req = 1'b0; rst_i = 1'b1;
    step();
    chk_reset("mid reset");
    rst_i = 1'b0;
    n = issq.size();
    repeat (RETRY_GAP + TIMEOUT) step();
    chk("no event after reset", evq.size(), 0);
    chk("no reissue after reset", issq.size(), n);
    run_vec(model('{0, 1'b0, 1'b0, 24'h0D0D0D, 32'h0, 0, 0, 4, 32'h76543210, 1'b0, 0, 0}), "post reset");

    for (int i = 0; i < 30; i++) begin
      int r;
      v.port = $urandom_range(0, 1); v.we = 1'($urandom); v.erase = 1'($urandom);
      v.adr = 24'($urandom); v.dat = $urandom; v.rdat = $urandom;
      v.n_rty = $urandom_range(0, MAX_RETRY + 1);
      r = $urandom_range(0, 9);
      v.fin = (r < 6) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      v.dly = $urandom_range(0, 20);
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
